// File: rtl/board_row_prefetch_if.sv
// Bundles the CPU/RAM address path and the VGA row-buffer signals of board_row_prefetch.
// slave is the prefetcher side; master is the CPU/RAM/VGA environment side.
interface board_row_prefetch_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [2:0]            mem_q;
  logic                  row_req;
  logic [4:0]            row_sel;
  logic                  row_start;
  logic [3:0]            cell_x;
  logic [2:0]            cell_color;
  logic                  busy;
  logic                  ready;
  logic                  done;
  logic                  underrun;
  logic                  req_err;

  modport slave (
    input  cpu_req, cpu_addr, mem_q, row_req, row_sel, row_start, cell_x,
    output mem_addr, cell_color, busy, ready, done, underrun, req_err
  );

  modport master (
    output cpu_req, cpu_addr, mem_q, row_req, row_sel, row_start, cell_x,
    input  mem_addr, cell_color, busy, ready, done, underrun, req_err
  );
endinterface

// File: rtl/board_row_prefetch.sv
// Prefetches one board row from the shared RAM into a double-buffered row store using idle CPU cycles.
// Fetch takes ROW_CELLS+1 cycles plus one per CPU stall while issuing; the CPU always wins the RAM port.
module board_row_prefetch #(
  parameter int ROW_CELLS  = 10,
  parameter int ROWS       = 20,
  parameter int ADDR_WIDTH = 12,
  parameter int BASE_ADDR  = 0
) (
  input logic                 clock,
  input logic                 reset,
  board_row_prefetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] CELLS_A = ADDR_WIDTH'(ROW_CELLS);
  localparam logic [3:0]            CELLS_X = 4'(ROW_CELLS);
  localparam logic [3:0]            LAST    = 4'(ROW_CELLS - 1);
  localparam logic [5:0]            ROWS_L  = 6'(ROWS);

  state_t                state;
  logic [4:0]            row_q;
  logic [3:0]            issue_idx;
  logic [3:0]            cap_idx;
  logic                  cap_vld;
  logic                  sel;
  logic                  busy_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  underrun_q;
  logic                  req_err_q;
  logic [2:0]            bank [2][ROW_CELLS];
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  row_ok;
  logic                  accept;
  logic                  swap;

  assign row_ok = {1'b0, bus.row_sel} < ROWS_L;
  assign accept = bus.row_req && (state == IDLE) && row_ok;
  assign swap   = bus.row_start && ready_q;

  always_comb begin
    fetch_addr = BASE_A;
    if (state != IDLE) begin
      fetch_addr = BASE_A + ADDR_WIDTH'(row_q) * CELLS_A + ADDR_WIDTH'(issue_idx);
    end
  end

  assign bus.mem_addr   = bus.cpu_req ? bus.cpu_addr : fetch_addr;
  assign bus.cell_color = (bus.cell_x < CELLS_X) ? bank[sel][bus.cell_x] : 3'd0;
  assign bus.busy       = busy_q;
  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.underrun   = underrun_q;
  assign bus.req_err    = req_err_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      row_q      <= '0;
      issue_idx  <= '0;
      cap_idx    <= '0;
      cap_vld    <= 1'b0;
      sel        <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      req_err_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < ROW_CELLS; c++) begin
          bank[b][c] <= '0;
        end
      end
    end else begin
      done_q     <= 1'b0;
      cap_vld    <= 1'b0;
      // ready_q is still 0 on the completing edge, so a coincident row_start underruns
      underrun_q <= bus.row_start && !ready_q;
      req_err_q  <= bus.row_req && !((state == IDLE) && row_ok);

      // RAM data for an issue arrives one cycle later, whatever the CPU is doing then
      if (cap_vld) begin
        bank[~sel][cap_idx] <= bus.mem_q;
      end

      if (swap) begin
        sel     <= ~sel;
        ready_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            state     <= FETCH;
            row_q     <= bus.row_sel;
            issue_idx <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        FETCH: begin
          if (!bus.cpu_req) begin
            cap_vld   <= 1'b1;
            cap_idx   <= issue_idx;
            issue_idx <= issue_idx + 4'd1;
            if (issue_idx == LAST) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (cap_vld && (cap_idx == LAST)) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_row_prefetch.sv
// Directed bench for board_row_prefetch: a registered RAM model feeds mem_q, checks run #1-#2 after each rising edge.
module tb_board_row_prefetch;

  typedef struct {
    logic        cpu_req;
    logic [11:0] exp_addr;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nvec  = 0;
  int   nerr  = 0;
  int   cyc;
  int   seen;
  vec_t tbl [15];
  logic [2:0] ram [4096];

  always #5 clock = ~clock;

  board_row_prefetch_if #(.ADDR_WIDTH(12)) bus ();

  board_row_prefetch #(
    .ROW_CELLS(10), .ROWS(20), .ADDR_WIDTH(12), .BASE_ADDR(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clock) bus.mem_q <= ram[bus.mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_fetch(input logic [4:0] r);
    bus.row_req = 1'b1;
    bus.row_sel = r;
    step();
    bus.row_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!bus.done && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic check_row(input string name, input int base);
    for (int k = 0; k < 10; k++) begin
      bus.cell_x = 4'(k);
      #1;
      chk(name, 32'(bus.cell_color), 32'(ram[base + k]));
    end
  endtask

  initial begin
    // Stalled fetch of row 5: CPU owns cycles 3, 4, 8 (FETCH) and 14 (FLUSH)
    tbl[0]  = '{1'b0, 12'd50,  1'b1, 1'b0};
    tbl[1]  = '{1'b0, 12'd51,  1'b1, 1'b0};
    tbl[2]  = '{1'b1, 12'h7FF, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 12'h7FF, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 12'd52,  1'b1, 1'b0};
    tbl[5]  = '{1'b0, 12'd53,  1'b1, 1'b0};
    tbl[6]  = '{1'b0, 12'd54,  1'b1, 1'b0};
    tbl[7]  = '{1'b1, 12'h7FF, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 12'd55,  1'b1, 1'b0};
    tbl[9]  = '{1'b0, 12'd56,  1'b1, 1'b0};
    tbl[10] = '{1'b0, 12'd57,  1'b1, 1'b0};
    tbl[11] = '{1'b0, 12'd58,  1'b1, 1'b0};
    tbl[12] = '{1'b0, 12'd59,  1'b1, 1'b0};
    tbl[13] = '{1'b1, 12'h7FF, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 12'd0,   1'b0, 1'b1};

    for (int a = 0; a < 4096; a++) ram[a] = 3'((a * 5 + 3) % 8);
    for (int k = 0; k < 10; k++) ram[30 + k] = 3'(k % 8);

    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.row_req = 1'b0; bus.row_sel = '0;
    bus.row_start = 1'b0; bus.cell_x = '0;
    reset = 1'b0;
    step(); step();
    #1;
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_ready", 32'(bus.ready), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_underrun", 32'(bus.underrun), 0);
    chk("reset_req_err", 32'(bus.req_err), 0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 0);
    chk("reset_color", 32'(bus.cell_color), 0);
    reset = 1'b1;
    step();

    // Unstalled fetch of row 3
    start_fetch(5'd3);
    for (int c = 1; c <= 10; c++) begin
      #1;
      chk("fetch_addr", 32'(bus.mem_addr), 32'(29 + c));
      step();
    end
    chk("done_not_early", 32'(bus.done), 0);
    step();
    chk("done_e11", 32'(bus.done), 1);
    chk("ready_e11", 32'(bus.ready), 1);
    chk("busy_e11", 32'(bus.busy), 0);
    step();
    chk("done_one_cycle", 32'(bus.done), 0);
    bus.row_start = 1'b1;
    step();
    bus.row_start = 1'b0;
    chk("swap_ready_clr", 32'(bus.ready), 0);
    chk("swap_no_underrun", 32'(bus.underrun), 0);
    check_row("row3_cells", 30);
    bus.cell_x = 4'd12;
    #1;
    chk("cell_x_12", 32'(bus.cell_color), 0);
    step();

    // Stalled fetch, table-driven
    start_fetch(5'd5);
    for (int i = 0; i < 15; i++) begin
      bus.cpu_req  = tbl[i].cpu_req;
      bus.cpu_addr = 12'h7FF;
      #1;
      chk("stall_addr", 32'(bus.mem_addr), 32'(tbl[i].exp_addr));
      chk("stall_busy", 32'(bus.busy), 32'(tbl[i].exp_busy));
      chk("stall_done", 32'(bus.done), 32'(tbl[i].exp_done));
      step();
    end
    bus.cpu_req = 1'b0;
    bus.row_start = 1'b1;
    step();
    bus.row_start = 1'b0;
    check_row("row5_cells", 50);
    step();

    // row_req while busy is rejected and the running fetch is untouched
    start_fetch(5'd3);
    for (int i = 0; i < 5; i++) step();
    bus.row_req = 1'b1;
    bus.row_sel = 5'd7;
    step();
    bus.row_req = 1'b0;
    chk("busy_req_err", 32'(bus.req_err), 1);
    #1;
    chk("busy_req_addr", 32'(bus.mem_addr), 36);
    step();
    chk("busy_req_err_pulse", 32'(bus.req_err), 0);
    wait_done(20, cyc);
    chk("busy_req_done_cycle", 32'(cyc), 4);
    bus.row_start = 1'b1;
    step();
    bus.row_start = 1'b0;
    check_row("row3_kept", 30);
    step();

    bus.row_req = 1'b1;
    bus.row_sel = 5'd20;
    step();
    bus.row_req = 1'b0;
    chk("bad_row_req_err", 32'(bus.req_err), 1);
    chk("bad_row_busy", 32'(bus.busy), 0);
    step();

    // Underrun with nothing ready
    bus.cell_x = 4'd3;
    bus.row_start = 1'b1;
    step();
    bus.row_start = 1'b0;
    chk("idle_underrun", 32'(bus.underrun), 1);
    chk("idle_underrun_color", 32'(bus.cell_color), 3);
    step();

    // row_start coinciding with the done edge
    start_fetch(5'd5);
    for (int i = 0; i < 10; i++) step();
    bus.row_start = 1'b1;
    step();
    bus.row_start = 1'b0;
    chk("edge_done", 32'(bus.done), 1);
    chk("edge_underrun", 32'(bus.underrun), 1);
    chk("edge_ready", 32'(bus.ready), 1);
    chk("edge_color_kept", 32'(bus.cell_color), 3);
    step();
    chk("edge_ready_held", 32'(bus.ready), 1);
    bus.row_start = 1'b1;
    step();
    bus.row_start = 1'b0;
    chk("late_swap_ready", 32'(bus.ready), 0);
    chk("late_swap_underrun", 32'(bus.underrun), 0);
    chk("late_swap_color", 32'(bus.cell_color), 32'(ram[53]));
    step();

    // Reset mid-fetch
    start_fetch(5'd3);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    step();
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_ready", 32'(bus.ready), 0);
    for (int k = 0; k < 10; k++) begin
      bus.cell_x = 4'(k);
      #1;
      chk("abort_cleared", 32'(bus.cell_color), 0);
    end
    reset = 1'b1;
    step();
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) seen++;
      step();
    end
    chk("abort_no_done", 32'(seen), 0);
    start_fetch(5'd5);
    wait_done(30, cyc);
    chk("fresh_latency", 32'(cyc), 11);
    chk("fresh_ready", 32'(bus.ready), 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
